// File: rtl/bure_hazard_ctrl.sv
// Decode-stage issue controller: load scoreboard, RAW/WAW stall generation against
// outstanding loads, and redirect flush sequencing.
module bure_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_id_valid,
    input  logic [4:0]           i_id_rs1_addr,
    input  logic [4:0]           i_id_rs2_addr,
    input  logic [4:0]           i_id_rd_addr,
    input  logic                 i_id_rd_wen,
    input  logic                 i_id_is_load_op,
    input  logic                 i_wb_valid,
    input  logic [4:0]           i_wb_rd_addr,
    input  logic                 i_redirect,
    output logic                 o_issue,
    output logic                 o_stall,
    output logic                 o_flush,
    output logic [31:0]          o_busy_mask,
    output logic [CNT_WIDTH-1:0] o_stall_cnt
);

    localparam int unsigned FcntW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FcntW-1:0] FlushReload = FcntW'(FLUSH_CYCLES - 1);
    localparam logic [FcntW-1:0] FcntOne = FcntW'(1);

    typedef enum logic [0:0] {StRun, StFlush} state_e;

    state_e               state_q, state_d;
    logic [FcntW-1:0]     flush_cnt_q, flush_cnt_d;
    logic [31:0]          busy_q, busy_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    logic hz;
    logic flush;
    logic stall;
    logic issue;

    // Hazard check sees only the registered mask: a write-back clear is not bypassed.
    always_comb begin
        hz    = i_id_valid & (busy_q[i_id_rs1_addr] | busy_q[i_id_rs2_addr] |
                              (i_id_rd_wen & busy_q[i_id_rd_addr]));
        flush = ~i_rst & (i_redirect | (state_q == StFlush));
        stall = ~i_rst & hz & ~flush;
        issue = ~i_rst & i_id_valid & ~hz & ~flush;
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        unique case (state_q)
            StRun: begin
                if (i_redirect && (FLUSH_CYCLES > 1)) begin
                    state_d     = StFlush;
                    flush_cnt_d = FlushReload;
                end
            end
            StFlush: begin
                if (i_redirect) begin
                    flush_cnt_d = FlushReload;
                end else begin
                    flush_cnt_d = flush_cnt_q - FcntOne;
                    if (flush_cnt_q <= FcntOne) begin
                        state_d = StRun;
                    end
                end
            end
            default: begin
                state_d     = StRun;
                flush_cnt_d = '0;
            end
        endcase
    end

    // Set is applied after clear so a same-cycle new load to the register stays pending.
    always_comb begin
        busy_d = busy_q;
        if (i_wb_valid && (i_wb_rd_addr != 5'd0)) begin
            busy_d[i_wb_rd_addr] = 1'b0;
        end
        if (issue && i_id_is_load_op && i_id_rd_wen && (i_id_rd_addr != 5'd0)) begin
            busy_d[i_id_rd_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StRun;
            flush_cnt_q <= '0;
            busy_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_issue     = issue;
    assign o_stall     = stall;
    assign o_flush     = flush;
    assign o_busy_mask = busy_q;
    assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_bure_hazard_ctrl.sv
// Directed bench for bure_hazard_ctrl: stimulus pushes hand-computed expectations into
// a queue, a negedge monitor pops and compares them against the DUT outputs.
module tb_bure_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  rs1, rs2, rd;
    logic        rd_wen, is_load;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        redirect;
    logic        issue, stall, flush;
    logic [31:0] busy_mask;
    logic [31:0] stall_cnt;

    typedef struct {
        int          id;
        logic        issue;
        logic        stall;
        logic        flush;
        logic [31:0] mask;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_id = 0;

    always #5 clk = ~clk;

    bure_hazard_ctrl #(
        .FLUSH_CYCLES(2),
        .CNT_WIDTH   (32)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_id_valid     (id_valid),
        .i_id_rs1_addr  (rs1),
        .i_id_rs2_addr  (rs2),
        .i_id_rd_addr   (rd),
        .i_id_rd_wen    (rd_wen),
        .i_id_is_load_op(is_load),
        .i_wb_valid     (wb_valid),
        .i_wb_rd_addr   (wb_rd),
        .i_redirect     (redirect),
        .o_issue        (issue),
        .o_stall        (stall),
        .o_flush        (flush),
        .o_busy_mask    (busy_mask),
        .o_stall_cnt    (stall_cnt)
    );

    task automatic check(input string name, input int id, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, id, act, req);
        end
    endtask

    // Monitor: one expectation per driven cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("issue", e.id, {31'd0, issue}, {31'd0, e.issue});
            check("stall", e.id, {31'd0, stall}, {31'd0, e.stall});
            check("flush", e.id, {31'd0, flush}, {31'd0, e.flush});
            check("busy_mask", e.id, busy_mask, e.mask);
            check("stall_cnt", e.id, stall_cnt, e.cnt);
        end
    end

    task automatic cyc(input logic r, input logic v, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] d, input logic w, input logic ld, input logic wbv,
                       input logic [4:0] wbd, input logic rdr, input logic ei, input logic es,
                       input logic ef, input logic [31:0] em, input logic [31:0] ec);
        exp_t e;
        @(posedge clk);
        #1;
        rst      = r;
        id_valid = v;
        rs1      = a1;
        rs2      = a2;
        rd       = d;
        rd_wen   = w;
        is_load  = ld;
        wb_valid = wbv;
        wb_rd    = wbd;
        redirect = rdr;
        cyc_id++;
        e.id    = cyc_id;
        e.issue = ei;
        e.stall = es;
        e.flush = ef;
        e.mask  = em;
        e.cnt   = ec;
        exp_q.push_back(e);
    endtask

    initial begin
        rst      = 1'b1;
        id_valid = 1'b0;
        rs1      = 5'd0;
        rs2      = 5'd0;
        rd       = 5'd0;
        rd_wen   = 1'b0;
        is_load  = 1'b0;
        wb_valid = 1'b0;
        wb_rd    = 5'd0;
        redirect = 1'b0;

        //   rst v  rs1 rs2 rd  wen ld wbv wbrd rdr  iss stl fl mask          cnt
        // Reset state
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 32'h0, 0);
        // Load-use on x5, write-back three cycles later
        cyc(0, 1, 1, 2, 5, 1, 1, 0, 0, 0,        1, 0, 0, 32'h0, 0);
        cyc(0, 1, 5, 0, 6, 1, 0, 0, 0, 0,        0, 1, 0, 32'h20, 0);
        cyc(0, 1, 5, 0, 6, 1, 0, 0, 0, 0,        0, 1, 0, 32'h20, 1);
        cyc(0, 1, 5, 0, 6, 1, 0, 1, 5, 0,        0, 1, 0, 32'h20, 2);
        cyc(0, 1, 5, 0, 6, 1, 0, 0, 0, 0,        1, 0, 0, 32'h0, 3);
        // Load to x0 never marks busy; WAW on x7 stalls, rd without wen does not
        cyc(0, 1, 1, 2, 0, 1, 1, 0, 0, 0,        1, 0, 0, 32'h0, 3);
        cyc(0, 1, 1, 2, 7, 1, 1, 0, 0, 0,        1, 0, 0, 32'h0, 3);
        cyc(0, 1, 1, 2, 7, 0, 0, 0, 0, 0,        1, 0, 0, 32'h80, 3);
        cyc(0, 1, 1, 2, 7, 1, 0, 0, 0, 0,        0, 1, 0, 32'h80, 3);
        cyc(0, 1, 1, 2, 7, 1, 0, 1, 7, 0,        0, 1, 0, 32'h80, 4);
        cyc(0, 1, 1, 2, 7, 1, 0, 0, 0, 0,        1, 0, 0, 32'h0, 5);
        // Redirect during a stall: two flush cycles, stall suppressed
        cyc(0, 1, 1, 2, 3, 1, 1, 0, 0, 0,        1, 0, 0, 32'h0, 5);
        cyc(0, 1, 3, 0, 4, 1, 0, 0, 0, 0,        0, 1, 0, 32'h8, 5);
        cyc(0, 1, 3, 0, 4, 1, 0, 0, 0, 1,        0, 0, 1, 32'h8, 6);
        cyc(0, 1, 3, 0, 4, 1, 0, 0, 0, 0,        0, 0, 1, 32'h8, 6);
        cyc(0, 1, 3, 0, 4, 1, 0, 0, 0, 0,        0, 1, 0, 32'h8, 6);
        cyc(0, 0, 3, 0, 4, 1, 0, 1, 3, 0,        0, 0, 0, 32'h8, 7);
        // Back-to-back redirect: three flush cycles, no issue while flushing
        cyc(0, 1, 1, 2, 4, 1, 0, 0, 0, 1,        0, 0, 1, 32'h0, 7);
        cyc(0, 1, 1, 2, 4, 1, 0, 0, 0, 1,        0, 0, 1, 32'h0, 7);
        cyc(0, 1, 1, 2, 4, 1, 0, 0, 0, 0,        0, 0, 1, 32'h0, 7);
        cyc(0, 1, 1, 2, 4, 1, 0, 0, 0, 0,        1, 0, 0, 32'h0, 7);
        // Same-cycle set and clear of x9, then clear of a non-busy register
        cyc(0, 1, 1, 2, 9, 1, 1, 1, 9, 0,        1, 0, 0, 32'h0, 7);
        cyc(0, 1, 1, 2, 8, 1, 1, 1, 1, 0,        1, 0, 0, 32'h200, 7);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 9, 0,        0, 0, 0, 32'h300, 7);
        // Build mask 0x120, enter FLUSH, then reset
        cyc(0, 1, 1, 2, 5, 1, 1, 0, 0, 0,        1, 0, 0, 32'h100, 7);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,        0, 0, 1, 32'h120, 7);
        cyc(1, 1, 5, 8, 10, 1, 0, 0, 0, 0,       0, 0, 0, 32'h120, 7);
        cyc(0, 1, 5, 8, 10, 1, 0, 0, 0, 0,       1, 0, 0, 32'h0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 32'h0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
